// File: rtl/arb_pkg.sv
// Shared types and helpers for the bus arbiter and related priority logic.
package arb_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
module rr_picker
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDW     = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDW-1:0]     win_idx,
    output logic               any
);

    logic [IDW:0]   cand;
    logic [IDW-1:0] idx;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = '0;
        idx     = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (IDW+1)'(ptr) + (IDW+1)'(off);
            // Explicit wrap so non-power-of-two requester counts work.
            if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
            idx = cand[IDW-1:0];
            if (!any && req[idx]) begin
                any     = 1'b1;
                win_idx = idx;
                win_oh  = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with lock, turnaround dead cycles and CPU halt.
// Define ARB_TIMEOUT_EN to enable grant preemption after MAX_HOLD cycles.
module bus_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned TURN_CYCLES = 1,
    parameter  int unsigned MAX_HOLD    = 8,
    localparam int unsigned IDW         = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               gnt_valid,
    output logic               hlt_cpu,
    output logic               preempt
);

    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TURN_CYCLES < 1 || TURN_CYCLES > 3 ||
        MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
        $error("bus_arbiter: parameter out of range");
    end

    arb_state_e         state, state_nxt;
    logic [IDW-1:0]     rr_ptr, rr_ptr_nxt;
    logic [1:0]         turn_cnt, turn_cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDW-1:0]     gnt_id_nxt;
    logic               hlt_nxt;
    logic               arbitrate;
    logic               own_req, own_lock;
    logic [IDW-1:0]     ptr_after_owner;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;

`ifdef ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              timeout;
    logic              preempt_nxt;
    logic              others_req;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (req),
        .ptr     (rr_ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign own_req         = req[gnt_id];
    assign own_lock        = lock[gnt_id];
    assign ptr_after_owner = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
`ifdef ARB_TIMEOUT_EN
    assign others_req      = |(req & ~gnt);
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        turn_cnt_nxt = turn_cnt;
        gnt_nxt      = gnt;
        gnt_id_nxt   = gnt_id;
        hlt_nxt      = hlt_cpu;
        arbitrate    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_nxt     = hold_cnt;
        preempt_nxt  = 1'b0;
        timeout      = (hold_cnt == HOLD_LAST) && !own_lock && others_req;
`endif

        case (state)
            IDLE: arbitrate = 1'b1;
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                if (!(own_req || own_lock) || timeout) begin
                    preempt_nxt = timeout;
`else
                if (!(own_req || own_lock)) begin
`endif
                    state_nxt    = TURN;
                    gnt_nxt      = '0;
                    turn_cnt_nxt = '0;
                    rr_ptr_nxt   = ptr_after_owner;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt != '1) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
`endif
            end
            TURN: begin
                if (turn_cnt == TURN_LAST) arbitrate = 1'b1;
                else                       turn_cnt_nxt = turn_cnt + 2'd1;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                hlt_nxt   = 1'b0;
            end
        endcase

        // Shared by IDLE and the last TURN cycle; rr_ptr already skips the last owner.
        if (arbitrate) begin
            if (pick_any) begin
                state_nxt  = GRANT;
                gnt_nxt    = pick_oh;
                gnt_id_nxt = pick_idx;
                hlt_nxt    = (pick_idx != '0);
`ifdef ARB_TIMEOUT_EN
                hold_nxt   = '0;
`endif
            end else begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                hlt_nxt   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            turn_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hlt_cpu   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            turn_cnt  <= turn_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= |gnt_nxt;
            hlt_cpu   <= hlt_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            hold_cnt <= hold_nxt;
            preempt  <= preempt_nxt;
        end
    end
`else
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (NUM_REQ=4, TURN_CYCLES=1, MAX_HOLD=8).
module tb_bus_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TC = 1;
    localparam int unsigned MH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] lock = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       hlt_cpu;
    logic       preempt;

    bus_arbiter #(.NUM_REQ(N), .TURN_CYCLES(TC), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .hlt_cpu   (hlt_cpu),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];

    // Reference model state: 0 idle, 1 grant, 2 turn.
    int         m_state, m_id, m_ptr, m_hold, m_turn;
    logic [3:0] m_gnt;
    logic       m_hlt, m_pre;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {gnt, gnt_valid ? gnt_id : 2'b00, gnt_valid, hlt_cpu, preempt};
    endfunction

    function automatic logic [8:0] model_vec();
        return {m_gnt, (m_gnt != 4'b0) ? 2'(m_id) : 2'b00, |m_gnt, m_hlt, m_pre};
    endfunction

    task automatic model_reset();
        m_state = 0; m_id = 0; m_ptr = 0; m_hold = 0; m_turn = 0;
        m_gnt = '0; m_hlt = 1'b0; m_pre = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_pick(input logic [3:0] r);
        int  w;
        w = -1;
        for (int i = 0; i < 4; i++) begin
            if (w < 0 && r[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
        end
        if (w >= 0) begin
            m_state = 1; m_id = w; m_gnt = 4'b0001 << w; m_hold = 0; m_hlt = (w != 0);
        end else begin
            m_state = 0; m_gnt = '0; m_hlt = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] l);
        logic to;
        m_pre = 1'b0;
        to = 1'b0;
        case (m_state)
            0: model_pick(r);
            1: begin
`ifdef ARB_TIMEOUT_EN
                to = (m_hold == MH - 1) && !l[m_id] && ((r & ~(4'b0001 << m_id)) != 4'b0);
`endif
                if (!(r[m_id] || l[m_id]) || to) begin
                    m_state = 2; m_gnt = '0; m_turn = 0; m_ptr = (m_id + 1) % 4; m_pre = to;
                end else if (m_hold < 255) begin
                    m_hold++;
                end
            end
            default: begin
                if (m_turn == TC - 1) model_pick(r);
                else m_turn++;
            end
        endcase
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        lock = l;
        model_step(r, l);
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        check_eq("cycle", 32'(dut_vec()), 32'(exp_q.pop_front()));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("reset_state", 32'(dut_vec()), 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        int         order[$];
        int         held, gap, prev_id, cnt, pre_cnt;
        logic       prev_valid;
        logic [3:0] r;

        // Single request, release, turnaround then idle.
        do_reset();
        step(4'b0100, 4'b0000);
        check_eq("single_gnt", 32'(gnt), 32'h4);
        check_eq("single_id", 32'(gnt_id), 32'd2);
        check_eq("single_hlt", 32'(hlt_cpu), 32'd1);
        for (int i = 1; i < 5; i++) step(4'b0100, 4'b0000);
        step(4'b0000, 4'b0000);
        check_eq("single_turn_gnt", 32'(gnt), 32'd0);
        check_eq("single_turn_hlt", 32'(hlt_cpu), 32'd1);
        step(4'b0000, 4'b0000);
        check_eq("single_idle_hlt", 32'(hlt_cpu), 32'd0);

        // Fairness: all request, each owner drops after holding two extra cycles.
        do_reset();
        held = 0; gap = 0; prev_id = -1; prev_valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            r = 4'b1111;
            if (gnt_valid && held == 2) r[gnt_id] = 1'b0;
            step(r, 4'b0000);
            if (gnt_valid) begin
                if (prev_valid && int'(gnt_id) == prev_id) begin
                    held++;
                end else begin
                    if (order.size() > 0) check_eq("fair_gap", 32'(gap), 32'd1);
                    order.push_back(int'(gnt_id));
                    held = 0;
                end
                gap = 0;
                prev_id = int'(gnt_id);
            end else begin
                gap++;
            end
            prev_valid = gnt_valid;
        end
        check_eq("fair_count", 32'(order.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < order.size()) check_eq("fair_order", 32'(order[k]), 32'(k % 4));
        end

        // Lock: owner 1 keeps bus on lock alone; foreign lock is ignored.
        do_reset();
        step(4'b0010, 4'b0000);
        cnt = 0; pre_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b1000, (i >= 10) ? 4'b1010 : 4'b0010);
            if (gnt == 4'b0010) cnt++;
            if (preempt) pre_cnt++;
        end
        check_eq("lock_held", 32'(cnt), 32'd20);
        check_eq("lock_no_preempt", 32'(pre_cnt), 32'd0);
        step(4'b1000, 4'b0000);
        check_eq("lock_turn", 32'(gnt), 32'd0);
        step(4'b1000, 4'b0000);
        check_eq("lock_next", 32'(gnt), 32'h8);

        // Timeout scenario: req[3] held, req[0] joins at grant cycle 2.
        do_reset();
        step(4'b1000, 4'b0000);
        cnt = (gnt == 4'b1000) ? 1 : 0;
        pre_cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            step((i - 1 >= 2) ? 4'b1001 : 4'b1000, 4'b0000);
            if (gnt == 4'b1000) cnt++;
            if (preempt) pre_cnt++;
        end
`ifdef ARB_TIMEOUT_EN
        check_eq("to_hold", 32'(cnt), 32'd8);
        check_eq("to_preempt", 32'(pre_cnt), 32'd1);
        check_eq("to_final_gnt", 32'(gnt), 32'h1);
        check_eq("to_final_hlt", 32'(hlt_cpu), 32'd0);
`else
        check_eq("to_hold", 32'(cnt), 32'd15);
        check_eq("to_preempt", 32'(pre_cnt), 32'd0);
        check_eq("to_final_gnt", 32'(gnt), 32'h8);
`endif

        // Asynchronous reset in the middle of a grant, with rr_ptr away from 0.
        do_reset();
        step(4'b0100, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0010, 4'b0000);
        check_eq("pre_rst_gnt", 32'(gnt), 32'h2);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_gnt", 32'(gnt), 32'd0);
        check_eq("async_rst_valid", 32'(gnt_valid), 32'd0);
        check_eq("async_rst_hlt", 32'(hlt_cpu), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_eq("held_rst", 32'(dut_vec()), 32'd0);
        reset = 1'b1;
        step(4'b0010, 4'b0000);
        check_eq("post_rst_gnt", 32'(gnt), 32'h2);
        step(4'b0000, 4'b0000);
        do_reset();
        step(4'b1001, 4'b0000);
        check_eq("post_rst_ptr", 32'(gnt), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
